// File: rtl/mem_access_stage_if.sv
// Word-wide data-memory req/ack bus between the MEM stage (master) and data memory (slave).
// req/we/addr/wdata come from registers in the master; rdata is sampled only while ack is high.
interface mem_access_stage_if;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata;
    logic        dmem_ack;

    modport master (
        output dmem_req,
        output dmem_we,
        output dmem_addr,
        output dmem_wdata,
        input  dmem_rdata,
        input  dmem_ack
    );

    modport slave (
        input  dmem_req,
        input  dmem_we,
        input  dmem_addr,
        input  dmem_wdata,
        output dmem_rdata,
        output dmem_ack
    );
endinterface

// File: rtl/mem_access_stage.sv
// MEM-stage load/store unit: a non-memory op passes through in 0 extra cycles; an aligned memory op takes IDLE + N BUSY + 1 DONE cycles.
// The upstream pipeline is held by stall while a request is being issued or is outstanding; a misaligned op or a bus timeout drops the writeback.
module mem_access_stage #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       ex_valid,
    input  logic [31:0]                alu_res,
    input  logic [31:0]                B_in,
    input  logic [31:0]                regWrAddr_in,
    input  logic                       MemRead_in,
    input  logic                       MemWr_in,
    input  logic                       MemtoReg_in,
    input  logic                       RegWr_in,
    output logic                       stall,
    mem_access_stage_if.master         dmem,
    output logic [31:0]                mem_out,
    output logic [31:0]                B_out,
    output logic [31:0]                regWrAddr_out,
    output logic                       MemtoReg_out,
    output logic                       RegWr_out,
    output logic                       align_err,
    output logic                       bus_err
);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE_OK,
        DONE_ERR
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [CNT_W-1:0]   busy_cnt;
    logic [CNT_W-1:0]   busy_cnt_inc;
    logic [31:0]        load_q;
    logic               mem_op;
    logic               misaligned;
    logic               timeout_hit;
    logic               out_pass;

    assign mem_op       = ex_valid & (MemRead_in | MemWr_in);
    assign misaligned   = (alu_res[1:0] != 2'b00);
    assign busy_cnt_inc = busy_cnt + 1'b1;
    assign timeout_hit  = (busy_cnt_inc == CNT_W'(TIMEOUT));

    always_comb begin
        state_nxt = state;
        stall     = 1'b0;
        align_err = 1'b0;
        out_pass  = 1'b0;
        case (state)
            IDLE: begin
                if (mem_op) begin
                    if (misaligned) begin
                        align_err = 1'b1;
                    end else begin
                        stall     = 1'b1;
                        state_nxt = BUSY;
                    end
                end else if (ex_valid) begin
                    out_pass = 1'b1;
                end
            end
            BUSY: begin
                stall = 1'b1;
                // An ack landing on the timeout cycle still completes normally.
                if (dmem.dmem_ack) begin
                    state_nxt = DONE_OK;
                end else if (timeout_hit) begin
                    state_nxt = DONE_ERR;
                end
            end
            DONE_OK: begin
                out_pass  = 1'b1;
                state_nxt = IDLE;
            end
            DONE_ERR: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // EX/MEM is frozen by stall, so the completed op's fields are still on the inputs in DONE.
    assign B_out         = out_pass ? alu_res      : 32'h0;
    assign regWrAddr_out = out_pass ? regWrAddr_in : 32'h0;
    assign MemtoReg_out  = out_pass & MemtoReg_in;
    assign RegWr_out     = out_pass & RegWr_in;
    assign mem_out       = (state == DONE_OK && !dmem.dmem_we) ? load_q : 32'h0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dmem.dmem_req   <= 1'b0;
            dmem.dmem_we    <= 1'b0;
            dmem.dmem_addr  <= 32'h0;
            dmem.dmem_wdata <= 32'h0;
            busy_cnt        <= '0;
            load_q          <= 32'h0;
            bus_err         <= 1'b0;
        end else begin
            bus_err <= (state == BUSY) && (state_nxt == DONE_ERR);
            case (state)
                IDLE: begin
                    if (state_nxt == BUSY) begin
                        dmem.dmem_req   <= 1'b1;
                        dmem.dmem_we    <= MemWr_in;
                        dmem.dmem_addr  <= alu_res;
                        dmem.dmem_wdata <= B_in;
                        busy_cnt        <= '0;
                    end
                end
                BUSY: begin
                    if (dmem.dmem_ack) begin
                        dmem.dmem_req <= 1'b0;
                        if (!dmem.dmem_we) begin
                            load_q <= dmem.dmem_rdata;
                        end
                    end else if (timeout_hit) begin
                        dmem.dmem_req <= 1'b0;
                    end else begin
                        busy_cnt <= busy_cnt_inc;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage with TIMEOUT=4; inputs change on the falling edge, outputs are checked 1 time unit later.
module tb_mem_access_stage;

    logic        clk;
    logic        rst_n;
    logic        ex_valid;
    logic [31:0] alu_res;
    logic [31:0] B_in;
    logic [31:0] regWrAddr_in;
    logic        MemRead_in;
    logic        MemWr_in;
    logic        MemtoReg_in;
    logic        RegWr_in;
    logic        stall;
    logic [31:0] mem_out;
    logic [31:0] B_out;
    logic [31:0] regWrAddr_out;
    logic        MemtoReg_out;
    logic        RegWr_out;
    logic        align_err;
    logic        bus_err;

    int n_chk;
    int n_pass;

    mem_access_stage_if dmem ();

    mem_access_stage #(.TIMEOUT(4), .CNT_W(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ex_valid     (ex_valid),
        .alu_res      (alu_res),
        .B_in         (B_in),
        .regWrAddr_in (regWrAddr_in),
        .MemRead_in   (MemRead_in),
        .MemWr_in     (MemWr_in),
        .MemtoReg_in  (MemtoReg_in),
        .RegWr_in     (RegWr_in),
        .stall        (stall),
        .dmem         (dmem.master),
        .mem_out      (mem_out),
        .B_out        (B_out),
        .regWrAddr_out(regWrAddr_out),
        .MemtoReg_out (MemtoReg_out),
        .RegWr_out    (RegWr_out),
        .align_err    (align_err),
        .bus_err      (bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic drive_op(input logic vld, input logic rd, input logic wr,
                            input logic [31:0] addr, input logic [31:0] b,
                            input logic [31:0] rwa, input logic m2r, input logic rw);
        ex_valid     = vld;
        MemRead_in   = rd;
        MemWr_in     = wr;
        alu_res      = addr;
        B_in         = b;
        regWrAddr_in = rwa;
        MemtoReg_in  = m2r;
        RegWr_in     = rw;
    endtask

    task automatic bus(input logic ack, input logic [31:0] rdata);
        dmem.dmem_ack   = ack;
        dmem.dmem_rdata = rdata;
    endtask

    task automatic chk_bubble(input string tag);
        chk({tag, ".mem_out"},   mem_out,       32'h0);
        chk({tag, ".B_out"},     B_out,         32'h0);
        chk({tag, ".regwa"},     regWrAddr_out, 32'h0);
        chk({tag, ".m2r"},       32'(MemtoReg_out), 32'h0);
        chk({tag, ".regwr"},     32'(RegWr_out),    32'h0);
    endtask

    initial begin
        n_chk  = 0;
        n_pass = 0;
        rst_n  = 1'b0;
        drive_op(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
        bus(1'b0, 32'h0);

        // Reset state
        #1;
        chk("rst.stall", 32'(stall), 32'h0);
        chk("rst.req",   32'(dmem.dmem_req), 32'h0);
        chk("rst.we",    32'(dmem.dmem_we), 32'h0);
        chk("rst.addr",  dmem.dmem_addr, 32'h0);
        chk("rst.wdata", dmem.dmem_wdata, 32'h0);
        chk("rst.buserr", 32'(bus_err), 32'h0);
        chk_bubble("rst");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Non-memory op passes straight through
        @(negedge clk);
        drive_op(1'b1, 1'b0, 1'b0, 32'h10, 32'h0, 32'd5, 1'b0, 1'b1);
        #1;
        chk("alu.stall", 32'(stall), 32'h0);
        chk("alu.B_out", B_out, 32'h10);
        chk("alu.regwa", regWrAddr_out, 32'd5);
        chk("alu.regwr", 32'(RegWr_out), 32'h1);
        chk("alu.mem_out", mem_out, 32'h0);
        chk("alu.req", 32'(dmem.dmem_req), 32'h0);

        // Load with ack on 3rd BUSY cycle
        @(negedge clk);
        drive_op(1'b1, 1'b1, 1'b0, 32'h100, 32'h0, 32'd7, 1'b1, 1'b1);
        #1;
        chk("ld.idle.stall", 32'(stall), 32'h1);
        chk("ld.idle.req",   32'(dmem.dmem_req), 32'h0);
        chk("ld.idle.regwr", 32'(RegWr_out), 32'h0);
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            if (k == 2) ex_valid = 1'b0;
            if (k == 3) begin
                ex_valid = 1'b1;
                bus(1'b1, 32'hDEADBEEF);
            end
            #1;
            chk($sformatf("ld.busy%0d.req", k),   32'(dmem.dmem_req), 32'h1);
            chk($sformatf("ld.busy%0d.addr", k),  dmem.dmem_addr, 32'h100);
            chk($sformatf("ld.busy%0d.we", k),    32'(dmem.dmem_we), 32'h0);
            chk($sformatf("ld.busy%0d.stall", k), 32'(stall), 32'h1);
            chk($sformatf("ld.busy%0d.regwr", k), 32'(RegWr_out), 32'h0);
        end
        @(negedge clk);
        bus(1'b0, 32'h0);
        #1;
        chk("ld.done.stall",   32'(stall), 32'h0);
        chk("ld.done.mem_out", mem_out, 32'hDEADBEEF);
        chk("ld.done.regwr",   32'(RegWr_out), 32'h1);
        chk("ld.done.m2r",     32'(MemtoReg_out), 32'h1);
        chk("ld.done.regwa",   regWrAddr_out, 32'd7);
        chk("ld.done.B_out",   B_out, 32'h100);
        chk("ld.done.req",     32'(dmem.dmem_req), 32'h0);

        // Store, ack on 1st BUSY cycle
        @(negedge clk);
        drive_op(1'b1, 1'b0, 1'b1, 32'h200, 32'h12345678, 32'd0, 1'b0, 1'b0);
        #1;
        chk("st.idle.stall", 32'(stall), 32'h1);
        @(negedge clk);
        bus(1'b1, 32'hFFFFFFFF);
        #1;
        chk("st.busy.req",   32'(dmem.dmem_req), 32'h1);
        chk("st.busy.we",    32'(dmem.dmem_we), 32'h1);
        chk("st.busy.wdata", dmem.dmem_wdata, 32'h12345678);
        chk("st.busy.addr",  dmem.dmem_addr, 32'h200);
        chk("st.busy.stall", 32'(stall), 32'h1);
        @(negedge clk);
        bus(1'b0, 32'h0);
        #1;
        chk("st.done.stall",   32'(stall), 32'h0);
        chk("st.done.mem_out", mem_out, 32'h0);
        chk("st.done.B_out",   B_out, 32'h200);
        chk("st.done.req",     32'(dmem.dmem_req), 32'h0);

        // Misaligned load is dropped
        @(negedge clk);
        drive_op(1'b1, 1'b1, 1'b0, 32'h102, 32'h0, 32'd3, 1'b1, 1'b1);
        #1;
        chk("mis.align_err", 32'(align_err), 32'h1);
        chk("mis.stall",     32'(stall), 32'h0);
        chk("mis.regwr",     32'(RegWr_out), 32'h0);
        chk("mis.req",       32'(dmem.dmem_req), 32'h0);
        @(negedge clk);
        drive_op(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
        #1;
        chk("mis.next.req",  32'(dmem.dmem_req), 32'h0);
        chk("mis.next.align_err", 32'(align_err), 32'h0);

        // Timeout with no ack
        @(negedge clk);
        drive_op(1'b1, 1'b1, 1'b0, 32'h300, 32'h0, 32'd9, 1'b1, 1'b1);
        #1;
        chk("to.idle.stall", 32'(stall), 32'h1);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            #1;
            chk($sformatf("to.busy%0d.req", k),    32'(dmem.dmem_req), 32'h1);
            chk($sformatf("to.busy%0d.buserr", k), 32'(bus_err), 32'h0);
        end
        @(negedge clk);
        #1;
        chk("to.done.req",    32'(dmem.dmem_req), 32'h0);
        chk("to.done.buserr", 32'(bus_err), 32'h1);
        chk("to.done.stall",  32'(stall), 32'h0);
        chk("to.done.regwr",  32'(RegWr_out), 32'h0);
        chk("to.done.mem_out", mem_out, 32'h0);
        @(negedge clk);
        drive_op(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
        #1;
        chk("to.after.buserr", 32'(bus_err), 32'h0);
        chk("to.after.req",    32'(dmem.dmem_req), 32'h0);

        // Ack on the 4th BUSY cycle beats the timeout
        @(negedge clk);
        drive_op(1'b1, 1'b1, 1'b0, 32'h304, 32'h0, 32'd10, 1'b1, 1'b1);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            if (k == 4) bus(1'b1, 32'hCAFEF00D);
            #1;
            chk($sformatf("ta.busy%0d.req", k), 32'(dmem.dmem_req), 32'h1);
        end
        @(negedge clk);
        bus(1'b0, 32'h0);
        #1;
        chk("ta.done.buserr",  32'(bus_err), 32'h0);
        chk("ta.done.mem_out", mem_out, 32'hCAFEF00D);
        chk("ta.done.regwr",   32'(RegWr_out), 32'h1);
        chk("ta.done.regwa",   regWrAddr_out, 32'd10);

        // Stray ack while IDLE is ignored
        @(negedge clk);
        drive_op(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
        bus(1'b1, 32'h55555555);
        #1;
        chk("idle_ack.req", 32'(dmem.dmem_req), 32'h0);
        @(negedge clk);
        bus(1'b0, 32'h0);
        #1;
        chk("idle_ack.next.req",   32'(dmem.dmem_req), 32'h0);
        chk("idle_ack.next.stall", 32'(stall), 32'h0);
        chk_bubble("idle_ack");

        // Reset asserted while BUSY
        @(negedge clk);
        drive_op(1'b1, 1'b1, 1'b0, 32'h400, 32'h0, 32'd2, 1'b1, 1'b1);
        @(negedge clk);
        #1;
        chk("rmid.busy.req", 32'(dmem.dmem_req), 32'h1);
        rst_n = 1'b0;
        #1;
        chk("rmid.rst.req",  32'(dmem.dmem_req), 32'h0);
        chk("rmid.rst.addr", dmem.dmem_addr, 32'h0);
        chk("rmid.rst.regwr", 32'(RegWr_out), 32'h0);
        drive_op(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        chk("rmid.after.req",   32'(dmem.dmem_req), 32'h0);
        chk("rmid.after.stall", 32'(stall), 32'h0);
        chk("rmid.after.buserr", 32'(bus_err), 32'h0);
        chk_bubble("rmid.after");
        @(negedge clk);
        #1;
        chk("rmid.after2.req",  32'(dmem.dmem_req), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
